seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture.sv | 138 +++++++++++++
 tb/tb_seg_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// Seven-segment scan capture: samples a multiplexed display bus, waits for a
// stable dwell on one digit, decodes the pattern and records a hex code per digit.
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_sel,
    output logic [15:0] code_out,
    output logic [3:0]  code_valid,
    output logic        frame_done,
    output logic        err
);

    typedef logic [3:0] cnt_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } decode_t;

    localparam cnt_t STABLE_MAX  = cnt_t'(STABLE_CYCLES);
    localparam cnt_t STABLE_LAST = cnt_t'(STABLE_CYCLES - 1);

    logic [10:0] s_q, sample_d;
    cnt_t        cnt_q, cnt_d;
    logic [15:0] code_q, code_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_q, frame_d;
    logic        err_q, err_d;

    logic        same;
    logic [3:0]  sel;
    logic        sel_onehot;
    logic        capture;
    decode_t     dec;

    function automatic decode_t decode(input logic [6:0] seg);
        decode_t r;
        r.hit  = 1'b1;
        r.code = 4'h0;
        case (seg)
            7'b1111110: r.code = 4'h0;
            7'b0110000: r.code = 4'h1;
            7'b1101101: r.code = 4'h2;
            7'b1111001: r.code = 4'h3;
            7'b0110011: r.code = 4'h4;
            7'b1011011: r.code = 4'h5;
            7'b1011111: r.code = 4'h6;
            7'b1110000: r.code = 4'h7;
            7'b1111111: r.code = 4'h8;
            7'b1111011: r.code = 4'h9;
            7'b1110111: r.code = 4'hA;
            7'b1100111: r.code = 4'hB;
            7'b0000001: r.code = 4'hC;
            7'b0010101: r.code = 4'hD;
            7'b1001111: r.code = 4'hE;
            7'b0000000: r.code = 4'hF;
            default:    r.hit  = 1'b0;
        endcase
        return r;
    endfunction

    assign sample_d   = {dig_sel, seg_in};
    assign same       = (sample_d == s_q);
    assign sel        = s_q[10:7];
    assign sel_onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    // Fires on the single edge where the count steps into saturation, so a
    // held pattern is captured exactly once.
    assign capture    = same && (cnt_q == STABLE_LAST) && sel_onehot;
    assign dec        = decode(s_q[6:0]);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers latches.
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        err_d   = 1'b0;

        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end

        if (capture) begin
            if (dec.hit) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        code_d[4*i +: 4] = dec.code;
                        valid_d[i]       = 1'b1;
                        seen_d[i]        = 1'b1;
                    end
                end
                if (seen_d == 4'hF) begin
                    frame_d = 1'b1;
                    seen_d  = 4'h0;
                end
            end else begin
                err_d   = 1'b1;
                valid_d = valid_q & ~sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them
        // update together from the values present before the edge.
        if (rst) begin
            s_q     <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s_q     <= sample_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign frame_done = frame_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: a dwell-length reference model predicts the
// outputs after every edge; a monitor compares them after each rising edge.
module tb_seg_capture;

    localparam int ST = 4;

    typedef struct packed {
        logic        fd;
        logic        err;
        logic [3:0]  valid;
        logic [15:0] code;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] code_out;
    logic [3:0]  code_valid;
    logic        frame_done;
    logic        err;

    always #5 clk = ~clk;

    seg_capture #(.STABLE_CYCLES(ST)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .code_out   (code_out),
        .code_valid (code_valid),
        .frame_done (frame_done),
        .err        (err)
    );

    logic [6:0] pat_tbl [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b1100111,
        7'b0000001, 7'b0010101, 7'b1001111, 7'b0000000
    };

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int fd_cnt = 0;

    exp_t sb_q [$];

    // Reference model: length of the current run of identical inputs, plus
    // per-digit code, valid and seen bookkeeping.
    int         run = 0;
    bit         prev_ok = 1'b0;
    logic [10:0] prev = '0;
    logic [3:0] m_code [4];
    bit         m_valid [4];
    bit         m_seen [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [3:0] d, input logic [6:0] s,
                              output exp_t e);
        int idx;
        int c;
        e.fd  = 1'b0;
        e.err = 1'b0;
        if (r) begin
            run = 0;
            prev_ok = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_code[i]  = 4'h0;
                m_valid[i] = 1'b0;
                m_seen[i]  = 1'b0;
            end
        end else begin
            if (prev_ok && ({d, s} == prev)) run = (run < 1000) ? run + 1 : run;
            else run = 1;
            prev = {d, s};
            prev_ok = 1'b1;
            // The change edge is run 1; capture lands STABLE edges later.
            if (run == ST + 1 && $countones(d) == 1) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (d[i]) idx = i;
                c = -1;
                for (int k = 0; k < 16; k++) if (pat_tbl[k] == s) c = k;
                if (c < 0) begin
                    e.err = 1'b1;
                    m_valid[idx] = 1'b0;
                end else begin
                    m_code[idx]  = 4'(c);
                    m_valid[idx] = 1'b1;
                    m_seen[idx]  = 1'b1;
                    if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
                        e.fd = 1'b1;
                        for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            e.code[4*i +: 4] = m_code[i];
            e.valid[i]       = m_valid[i];
        end
    endtask

    // Applies one input set, predicts the following edge, and returns after it.
    task automatic drive(input bit r, input logic [3:0] d, input logic [6:0] s);
        exp_t e;
        rst = r;
        dig_sel = d;
        seg_in = s;
        model_step(r, d, s, e);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input bit r, input logic [3:0] d, input logic [6:0] s, input int n);
        for (int k = 0; k < n; k++) drive(r, d, s);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("scoreboard", {10'b0, frame_done, err, code_valid, code_out},
                      {10'b0, e});
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (err === 1'b1) err_cnt++;
        end
    end

    initial begin : stim
        int e0;
        int f0;
        int len;
        int pick;
        bit r;
        logic [3:0] d;
        logic [6:0] s;

        // Reset state
        hold(1'b1, 4'b0000, 7'b0, 2);
        check("reset_code", 32'(code_out), 32'h0);
        check("reset_valid", 32'(code_valid), 32'h0);

        // Single digit '1': nothing after E0+3, captured after E0+4
        e0 = err_cnt;
        hold(1'b0, 4'b0001, 7'b0110000, 4);
        check("dwell_early_valid", 32'(code_valid), 32'h0);
        drive(1'b0, 4'b0001, 7'b0110000);
        check("dwell_code", 32'(code_out[3:0]), 32'h1);
        check("dwell_valid", 32'(code_valid), 32'h1);
        drive(1'b0, 4'b0001, 7'b0110000);
        check("dwell_no_err", 32'(err_cnt - e0), 32'h0);

        // Full frame 2,0,A,F
        hold(1'b1, 4'b0000, 7'b0, 1);
        e0 = err_cnt;
        f0 = fd_cnt;
        hold(1'b0, 4'b0001, 7'b1101101, 5);
        hold(1'b0, 4'b0010, 7'b1111110, 5);
        hold(1'b0, 4'b0100, 7'b1110111, 5);
        hold(1'b0, 4'b1000, 7'b0000000, 5);
        drive(1'b0, 4'b1000, 7'b0000000);
        check("frame_code", 32'(code_out), 32'h0000FA02);
        check("frame_valid", 32'(code_valid), 32'hF);
        check("frame_pulses", 32'(fd_cnt - f0), 32'h1);
        check("frame_no_err", 32'(err_cnt - e0), 32'h0);

        // Unmapped pattern on digit 2
        e0 = err_cnt;
        f0 = fd_cnt;
        hold(1'b0, 4'b0100, 7'b1010101, 6);
        check("bad_err_pulses", 32'(err_cnt - e0), 32'h1);
        check("bad_valid", 32'(code_valid), 32'hB);
        check("bad_code_kept", 32'(code_out[11:8]), 32'hA);
        check("bad_no_frame", 32'(fd_cnt - f0), 32'h0);

        // Toggling faster than the dwell
        e0 = err_cnt;
        f0 = fd_cnt;
        for (int k = 0; k < 8; k++)
            hold(1'b0, 4'b0001, (k % 2 == 0) ? 7'b0110000 : 7'b1111001, 3);
        check("toggle_code", 32'(code_out), 32'h0000FA02);
        check("toggle_valid", 32'(code_valid), 32'hB);
        check("toggle_pulses", 32'(err_cnt - e0 + fd_cnt - f0), 32'h0);

        // Two digits selected at once
        hold(1'b0, 4'b0011, 7'b1111111, 10);
        check("multi_code", 32'(code_out), 32'h0000FA02);
        check("multi_valid", 32'(code_valid), 32'hB);

        // Reset in the middle of a dwell
        hold(1'b0, 4'b1000, 7'b1111111, 4);
        drive(1'b1, 4'b1000, 7'b1111111);
        check("midrst_code", 32'(code_out), 32'h0);
        check("midrst_valid", 32'(code_valid), 32'h0);
        hold(1'b0, 4'b1000, 7'b1111111, 4);
        check("midrst_early", 32'(code_valid), 32'h0);
        drive(1'b0, 4'b1000, 7'b1111111);
        check("midrst_valid_after", 32'(code_valid), 32'h8);
        check("midrst_code_after", 32'(code_out), 32'h00008000);

        // Randomized dwells
        for (int n = 0; n < 120; n++) begin
            len = $urandom_range(1, 8);
            r = ($urandom_range(0, 14) == 0);
            pick = $urandom_range(0, 9);
            if (pick < 7) d = 4'b0001 << $urandom_range(0, 3);
            else if (pick == 7) d = 4'b0000;
            else d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) s = pat_tbl[$urandom_range(0, 15)];
            else s = 7'($urandom);
            if (r) len = 1;
            hold(r, d, s, len);
        end

        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
